// File: rtl/filter_sample_pacer.sv
// filter_sample_pacer: paces samples from a small FIFO into a band-pass
// filter core. It issues a one-cycle EN strobe with u held stable between
// strobes, and captures the filter output two cycles after each strobe.
// Optional build macro: PACER_ZERO_FILL_EN. When it is defined, an empty slot
// still strobes, with u=0. When it is undefined, an empty slot is skipped.
module filter_sample_pacer #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] period,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] u,
  output logic             EN,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] cap_data,
  output logic             cap_valid,
  output logic             underrun,
  output logic             busy,
  output logic [DIV_W-1:0] sample_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  logic [DIV_W-1:0] w_period_eff;
  logic [DIV_W-1:0] r_eff;
  logic [DIV_W-1:0] r_cnt;
  logic             r_stop_pend;
  logic             w_slot;
  logic             w_strobe;
  logic             w_stop_now;

  logic [WIDTH-1:0] r_u;
  logic             r_en;
  logic             r_en_d1;
  logic [WIDTH-1:0] r_cap_data;
  logic             r_cap_valid;
  logic             r_underrun;
  logic [DIV_W-1:0] r_sample_cnt;

  // Pointers carry one extra wrap bit, so full and empty can be told apart.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  // Periods below 2 are clamped. Otherwise EN could never drop between strobes.
  assign w_period_eff = (period < DIV_W'(2)) ? DIV_W'(2) : period;

  // The slot decision is made one cycle early because EN and u are registered.
  // A start in the decision cycle restarts the pacer, and that slot is skipped.
  assign w_slot     = (r_state == S_RUN) && !start && (r_cnt == DIV_W'(1));
  assign w_pop      = w_slot && !w_empty;
  assign w_stop_now = stop || r_stop_pend;
`ifdef PACER_ZERO_FILL_EN
  assign w_strobe   = w_slot;
`else
  assign w_strobe   = w_pop;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: start always (re)enters RUN; stop takes effect at a slot
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (start)                         w_state_nxt = S_RUN;
        else if (w_slot && w_stop_now)     w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic of the state machine
  always_comb begin
    busy = (r_state == S_RUN);
  end

  // Period counter, latched period and pending-stop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_eff       <= '0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      if (start) begin
        r_eff <= w_period_eff;
        r_cnt <= w_period_eff - DIV_W'(1);
      end else if (r_state == S_RUN) begin
        r_cnt <= (r_cnt == DIV_W'(1)) ? r_eff : r_cnt - DIV_W'(1);
      end
      if (start || w_slot)                r_stop_pend <= 1'b0;
      else if (stop && r_state == S_RUN)  r_stop_pend <= 1'b1;
    end
  end

  // FIFO storage; data only, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data;
  end

  // FIFO pointers; pops happen only at strobe slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Strobe, held sample, strobe count and sticky underrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_u          <= '0;
      r_en         <= 1'b0;
      r_sample_cnt <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_en <= w_strobe;
      if (w_pop)         r_u <= r_mem[r_rptr[AW-1:0]];
      else if (w_strobe) r_u <= '0;
      if (start)         r_sample_cnt <= '0;
      else if (w_strobe) r_sample_cnt <= r_sample_cnt + DIV_W'(1);
      if (start)                   r_underrun <= 1'b0;
      else if (w_slot && w_empty)  r_underrun <= 1'b1;
    end
  end

  // Capture y_in one cycle after a strobe; this is independent of RUN state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_d1     <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
    end else begin
      r_en_d1     <= r_en;
      r_cap_valid <= r_en_d1;
      if (r_en_d1) r_cap_data <= y_in;
    end
  end

  assign u          = r_u;
  assign EN         = r_en;
  assign cap_data   = r_cap_data;
  assign cap_valid  = r_cap_valid;
  assign underrun   = r_underrun;
  assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_filter_sample_pacer.sv
// Directed testbench for filter_sample_pacer.
// Samples pushed into the FIFO are mirrored in a queue. They are popped and
// compared at each EN. Capture expectations are queued at each EN and are
// compared when cap_valid appears. Follows PACER_ZERO_FILL_EN if defined.
module tb_filter_sample_pacer;
  localparam int WIDTH = 21;
  localparam int DEPTH = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] period;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] u;
  logic             EN;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] cap_data;
  logic             cap_valid;
  logic             underrun;
  logic             busy;
  logic [DIV_W-1:0] sample_cnt;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] data;
  } cap_t;

  logic [WIDTH-1:0] model_q[$];
  cap_t             cap_q[$];
  int               en_cyc[$];
  int               cyc;
  int               n_vec;
  int               n_err;

  always #5 clk = ~clk;

  filter_sample_pacer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .period(period), .start(start), .stop(stop),
    .u(u), .EN(EN), .y_in(y_in),
    .cap_data(cap_data), .cap_valid(cap_valid),
    .underrun(underrun), .busy(busy), .sample_cnt(sample_cnt)
  );

  function automatic logic [WIDTH-1:0] yf(input int c);
    return WIDTH'(c * 13 + 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record the push, advance, then check EN/u and captures mid-cycle
  task automatic tick();
    logic             pushed;
    logic [WIDTH-1:0] pd;
    logic [WIDTH-1:0] exp_u;
    cap_t             ce;
    pushed = in_valid && in_ready && rst;
    pd     = in_data;
    @(posedge clk);
    cyc++;
    if (pushed) model_q.push_back(pd);
    @(negedge clk);
    if (EN) begin
      en_cyc.push_back(cyc);
      if (model_q.size() > 0) begin
        exp_u = model_q.pop_front();
      end else begin
        exp_u = '0;
`ifndef PACER_ZERO_FILL_EN
        chk("en_with_empty_fifo", 32'(model_q.size()), 32'd1);
`endif
      end
      chk("u_at_EN", 32'(u), 32'(exp_u));
      ce.cyc  = cyc + 2;
      ce.data = yf(cyc + 1);
      cap_q.push_back(ce);
    end
    if (cap_valid) begin
      if (cap_q.size() == 0) begin
        chk("cap_unexpected", 32'(cap_valid), 32'd0);
      end else begin
        ce = cap_q.pop_front();
        chk("cap_cycle", 32'(cyc), 32'(ce.cyc));
        chk("cap_data", 32'(cap_data), 32'(ce.data));
      end
    end
    y_in = yf(cyc);
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [DIV_W-1:0] p, output int s);
    period = p;
    start  = 1'b1;
    s      = cyc;
    tick();
    start  = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      tick();
      k++;
    end
    chk("busy_low", 32'(busy), 32'd0);
  endtask

  task automatic drain();
    repeat (4) tick();
    chk("cap_drained", 32'(cap_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int s2;
    int acc;
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b0; in_data = '0; in_valid = 1'b0; period = '0;
    start = 1'b0; stop = 1'b0; y_in = '0;

    // Reset state
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_u", 32'(u), 32'd0);
    chk("rst_EN", 32'(EN), 32'd0);
    chk("rst_cap_valid", 32'(cap_valid), 32'd0);
    chk("rst_cap_data", 32'(cap_data), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);

    // Pacing: period 5, three samples
    en_cyc.delete();
    push(21'h00001); push(21'h00002); push(21'h00003);
    do_start(16'd5, s);
    chk("pace_busy", 32'(busy), 32'd1);
    repeat (16) tick();
    chk("pace_en_count", 32'(en_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < en_cyc.size(); i++)
      chk("pace_en_cycle", 32'(en_cyc[i] - s), 32'(5 * (i + 1)));
    chk("pace_sample_cnt", 32'(sample_cnt), 32'd3);
    do_stop();
    wait_idle(20);
    chk("pace_underrun", 32'(underrun), 32'd1);
    drain();

    // Minimum period: period 0 clamps to 2
    en_cyc.delete();
    push(21'h00010); push(21'h00011); push(21'h00012); push(21'h00013);
    do_start(16'd0, s);
    repeat (8) tick();
    chk("minp_en_count", 32'(en_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < en_cyc.size(); i++)
      chk("minp_en_cycle", 32'(en_cyc[i] - s), 32'(2 * (i + 1)));
    do_stop();
    wait_idle(20);
    drain();

    // Backpressure: hold in_valid for 10 cycles in IDLE
    en_cyc.delete();
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = WIDTH'(32'h100 + i);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd8);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    do_start(16'd3, s);
    chk("bp_ready_s1", 32'(in_ready), 32'd0);
    tick();
    chk("bp_ready_s2", 32'(in_ready), 32'd0);
    tick();
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    chk("bp_first_en", 32'(EN), 32'd1);
    repeat (21) tick();
    chk("bp_en_count", 32'(en_cyc.size()), 32'd8);
    chk("bp_sample_cnt", 32'(sample_cnt), 32'd8);
    do_stop();
    wait_idle(20);
    drain();

    // Underrun: one sample, period 4, three slots
    en_cyc.delete();
    push(21'h00055);
    do_start(16'd4, s);
    chk("ur_cleared_by_start", 32'(underrun), 32'd0);
    chk("ur_cnt_cleared", 32'(sample_cnt), 32'd0);
    repeat (12) tick();
    chk("ur_underrun", 32'(underrun), 32'd1);
`ifdef PACER_ZERO_FILL_EN
    chk("ur_en_count", 32'(en_cyc.size()), 32'd3);
    chk("ur_sample_cnt", 32'(sample_cnt), 32'd3);
`else
    chk("ur_en_count", 32'(en_cyc.size()), 32'd1);
    chk("ur_sample_cnt", 32'(sample_cnt), 32'd1);
`endif
    do_stop();
    wait_idle(20);
    drain();

    // Stop and restart: period 6, stop two cycles after a slot
    en_cyc.delete();
    push(21'h00201); push(21'h00202); push(21'h00203);
    push(21'h00204); push(21'h00205);
    do_start(16'd6, s);
    chk("sr_underrun_cleared", 32'(underrun), 32'd0);
    chk("sr_cnt_cleared", 32'(sample_cnt), 32'd0);
    repeat (7) tick();
    do_stop();
    wait_idle(20);
    chk("sr_idle_cycle", 32'(cyc - s), 32'd12);
    chk("sr_en_count", 32'(en_cyc.size()), 32'd2);
    chk("sr_sample_cnt", 32'(sample_cnt), 32'd2);
    chk("sr_underrun", 32'(underrun), 32'd0);
    repeat (10) tick();
    chk("sr_no_en_idle", 32'(en_cyc.size()), 32'd2);
    do_start(16'd6, s2);
    chk("sr_restart_cnt", 32'(sample_cnt), 32'd0);
    repeat (17) tick();
    chk("sr_restart_en", 32'(en_cyc.size()), 32'd5);
    chk("sr_restart_cnt3", 32'(sample_cnt), 32'd3);
    do_stop();
    wait_idle(20);
    drain();

    // Reset mid-RUN: strobe in flight, three samples still queued
    en_cyc.delete();
    push(21'h00301); push(21'h00302); push(21'h00303); push(21'h00304);
    do_start(16'd5, s);
    repeat (5) tick();
    chk("mr_en_before_rst", 32'(en_cyc.size()), 32'd1);
    rst = 1'b0;
    model_q.delete();
    cap_q.delete();
    tick();
    chk("mr_u", 32'(u), 32'd0);
    chk("mr_EN", 32'(EN), 32'd0);
    chk("mr_cap_valid", 32'(cap_valid), 32'd0);
    chk("mr_cap_data", 32'(cap_data), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_sample_cnt", 32'(sample_cnt), 32'd0);
    rst = 1'b1;
    tick();
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    repeat (6) tick();
    chk("mr_no_stale_en", 32'(en_cyc.size()), 32'd1);
    do_start(16'd2, s);
    repeat (4) tick();
    chk("mr_fifo_empty_underrun", 32'(underrun), 32'd1);
`ifdef PACER_ZERO_FILL_EN
    chk("mr_fifo_empty_cnt", 32'(sample_cnt), 32'd2);
`else
    chk("mr_fifo_empty_cnt", 32'(sample_cnt), 32'd0);
`endif
    do_stop();
    wait_idle(20);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/filter_sample_pacer.md
# filter_sample_pacer

Sample pacer that feeds the band-pass filter datapath (`Paso_Banda`-style cores with `u`/`EN` inputs) at a programmed sample rate and captures the filter's response. Upstream producers push samples through a valid/ready interface into a small FIFO. The pacer emits one-cycle `EN` strobes with `u` held stable between them, and returns the filter output one fixed latency after each strobe. It replaces bench-level stimulus pacing in on-chip use.

## Interface
- `WIDTH`, 21, sample width of `u` and of the captured filter output
- `DEPTH`, 8, FIFO depth in samples; power of two, at least 2
- `DIV_W`, 16, width of the period and sample-count fields
- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_data`  in  WIDTH  sample from producer
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  FIFO not full; a transfer occurs when `in_valid & in_ready`
- `period`  in  DIV_W  clocks between strobes; latched on `start`
- `start`  in  1  pulse; IDLE→RUN
- `stop`  in  1  pulse; RUN→IDLE at next period boundary
- `u`  out  WIDTH  sample to filter; registered
- `EN`  out  1  one-cycle strobe to filter
- `y_in`  in  WIDTH  filter output (y1)
- `cap_data`  out  WIDTH  captured filter output
- `cap_valid`  out  1  one-cycle pulse qualifying `cap_data`
- `underrun`  out  1  sticky; FIFO empty at a strobe slot; cleared by `start` or reset
- `busy`  out  1  high in RUN
- `sample_cnt`  out  DIV_W  strobes issued since `start`; wraps

## Operation
- Reset (`rst`=0, asynchronous): FIFO emptied, state IDLE, all counters 0, `u`=0, `EN`=0, `cap_data`=0, `cap_valid`=0, `underrun`=0, `busy`=0, `sample_cnt`=0. `in_ready` reads 1 once `rst` releases.
- FIFO: push on `in_valid & in_ready`. `in_ready = !full`. Pops happen only at strobe slots. It is never bypassed: a sample pushed in the same cycle as a strobe slot is not available to that slot.
- States:
  - IDLE: no strobes. The FIFO still accepts data.
  - RUN: the period counter runs.
- IDLE + `start`: latch `eff = max(period, 2)`, load the counter with `eff-1`, clear `sample_cnt` and `underrun`, enter RUN. `start` in RUN restarts the same way.
- RUN: the counter decrements each clock. When it reaches 0 (a slot), it reloads `eff-1`.
  - Slot with FIFO non-empty: pop, `u` ← head, `EN`=1 for one cycle, `sample_cnt` +1.
  - Slot with FIFO empty: `underrun` ← 1 and no strobe (see Configuration).
- `stop` in RUN sets a pending flag. At the next slot the pacer issues that slot normally, then enters IDLE. `stop` and `start` in the same cycle: `start` wins.
- Capture: for a strobe in cycle n, `cap_data` ← `y_in` at the edge ending cycle n+1, and `cap_valid`=1 in cycle n+2. Captures still complete if the pacer leaves RUN after the strobe.
- `u` holds its last value between strobes and in IDLE.

## Timing
- `start` in cycle s: first slot in cycle s+`eff`, then every `eff` cycles.
- Strobe → `cap_valid`: 2 cycles. Consecutive `cap_valid` pulses are at least 2 cycles apart.
- Push → earliest strobe using that sample: the next slot after the push edge.
- `in_ready` falls in the cycle after the push that fills the FIFO.
- Pop and push in the same cycle with the FIFO full: the push is not accepted because `in_ready` was 0.
- Pointers wrap modulo `DEPTH`. `sample_cnt` wraps from 2^DIV_W−1 to 0.
- Reset mid-RUN aborts immediately: in-flight captures are lost, FIFO contents are discarded, and no `cap_valid` follows.

## Configuration
- `PACER_ZERO_FILL_EN` defined: a slot with the FIFO empty still issues `EN`=1 with `u`=0, increments `sample_cnt`, and produces a capture. `underrun` is still set.
- `PACER_ZERO_FILL_EN` undefined: an empty slot produces no strobe and no capture, and `u` holds its value.

## Test plan
- Reset: assert `rst`=0 mid-RUN with 3 samples queued → all outputs at reset values and FIFO empty on release; no stale `cap_valid`.
- Pacing:
  - Stimulus: push 0x00001, 0x00002, 0x00003, then `period`=5, `start` at cycle s.
  - Required: `EN` at s+5, s+10, s+15 with `u`=1, 2, 3.
  - Required: `cap_valid` at s+7, s+12, s+17, with `cap_data` equal to `y_in` sampled at s+6, s+11, s+16.
  - Required: `sample_cnt`=3.
- Minimum period: `period`=0 with 4 samples queued → strobes every 2 cycles; 4 strobes, `EN` never high in adjacent cycles.
- Backpressure: `DEPTH`=8, IDLE, hold `in_valid` for 10 cycles → exactly 8 accepted, `in_ready`=0 after the 8th. `start` with `period`=3 → `in_ready` rises the cycle after the first pop.
- Underrun: 1 sample queued, `period`=4, run 3 slots.
  - Without the macro: 1 strobe, `underrun`=1, `sample_cnt`=1.
  - With the macro: 3 strobes, `u`=0 on strobes 2 and 3, `sample_cnt`=3.
- Stop and restart:
  - `stop` 2 cycles after a slot with `period`=6 → one more strobe at the next slot, then `busy`=0, and the remaining FIFO data is retained.
  - A following `start` clears `underrun` and `sample_cnt` and resumes with the retained data.
